execute_alu_issue_arbiter: RTL
==============================

EXECUTE_ALU_ISSUE_ARBITER -- requirements
Module: execute_alu_issue_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 6, meaning the width of the destination/ROB tag carried with each ALU op.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port i_flush  input  1  synchronous pipeline flush.
REQ-005 The block SHALL have ports i_req0_valid / i_req1_valid  input  1 each  requester N presents an ALU op.
REQ-006 The block SHALL have ports i_req0_alu_cmd / i_req1_alu_cmd  input  5 each  ALU command, same encoding as the ALU redecode stage.
REQ-007 The block SHALL have ports i_req0_tag / i_req1_tag  input  TAG_W each  destination tag.
REQ-008 The block SHALL have ports o_req0_ready / o_req1_ready  output  1 each  op of requester N accepted this cycle.
REQ-009 The block SHALL have port o_alu_valid  output  1  registered op valid toward the ALU redecode/execute stage.
REQ-010 The block SHALL have ports o_alu_cmd  output  5, o_alu_tag  output  TAG_W, and o_alu_src  output  1; together these carry the registered op and the index of the requester that won it.
REQ-011 The block SHALL have port i_alu_ready  input  1  downstream accepts the registered op this cycle.

Function
REQ-012 The block SHALL define load = !i_flush && (!o_alu_valid || i_alu_ready).
REQ-013 The block SHALL assert o_reqN_ready only when load=1, i_reqN_valid=1 and requester N is granted; both ready outputs SHALL never be high together.
REQ-014 Grant SHALL be round-robin: with exactly one request valid, that requester SHALL be granted; with both valid, the requester != last_grant SHALL be granted.
REQ-015 last_grant SHALL update to the granted index only on a cycle in which a grant occurs; it SHALL hold otherwise, including during flush.
REQ-016 On a grant, the output register SHALL capture cmd/tag/src of the winner and set o_alu_valid=1 on the next edge; accept-to-output latency SHALL be exactly 1 cycle.
REQ-017 When load=1 and no request is valid, o_alu_valid SHALL go to 0 on the next edge.
REQ-018 While o_alu_valid=1 and i_alu_ready=0, o_alu_cmd/o_alu_tag/o_alu_src/o_alu_valid SHALL hold stable and no requester SHALL see ready.
REQ-019 Throughput SHALL be one op per cycle when i_alu_ready=1 continuously (a simultaneous drain and refill in the same cycle is required).
REQ-020 i_flush=1 SHALL clear o_alu_valid on the next edge regardless of i_alu_ready, and SHALL force both o_reqN_ready=0 in that cycle; flush SHALL take priority over grant.
REQ-021 o_alu_cmd/o_alu_tag/o_alu_src SHALL be don't-care when o_alu_valid=0 but SHALL not change except on a grant.
REQ-022 Ready outputs SHALL depend combinationally on i_reqN_valid, i_alu_ready, i_flush and registered state only; there SHALL be no dependency on cmd or tag values.

Reset
REQ-023 Reset SHALL asynchronously force o_alu_valid=0, o_alu_cmd=0, o_alu_tag=0, o_alu_src=0, and last_grant=1, so that port 0 wins the first contended cycle.
REQ-024 Reset asserted mid-operation SHALL drop any registered op without it being presented to the ALU; ready outputs SHALL be 0 while reset is high.

Configuration
REQ-025 With macro EXECUTE_ALU_ARB_STAT_EN defined, the block SHALL add outputs o_stat_grant0 and o_stat_grant1 (output, 16 each), which count grants per requester, reset to 0, wrap 0xFFFF->0, and are not cleared by flush.
REQ-026 Without EXECUTE_ALU_ARB_STAT_EN, those ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-027 After reset, with req0 valid cmd=5'h01 tag=3 only and i_alu_ready=1, the bench SHALL check: o_req0_ready=1 in the same cycle; next cycle o_alu_valid=1, cmd=5'h01, tag=3, src=0.
REQ-028 With both requests held valid and i_alu_ready=1 for 6 cycles, the bench SHALL check that grants alternate 0,1,0,1,0,1 and that o_alu_valid stays 1 from cycle 2 on.
REQ-029 With an op registered (tag=7), i_alu_ready=0 for 3 cycles and both requests valid, the bench SHALL check: both ready outputs=0 and outputs stable at tag=7; when i_alu_ready=1, the next grant goes to the requester != last_grant.
REQ-030 With o_alu_valid=1, i_alu_ready=0 and i_flush=1 for one cycle while req1 is valid, the bench SHALL check: o_req1_ready=0 that cycle, o_alu_valid=0 the next cycle, and last_grant unchanged.
REQ-031 With reset asserted asynchronously mid-cycle while o_alu_valid=1, the bench SHALL check that o_alu_valid=0 immediately and that the next contended grant goes to port 0.
REQ-032 With EXECUTE_ALU_ARB_STAT_EN defined, after 0xFFFF req0-only grants plus 1 more, the bench SHALL check o_stat_grant0=0 and o_stat_grant1=0.

Source files
------------

// File: rtl/execute_alu_issue_arbiter.sv
// execute_alu_issue_arbiter
//
// Purpose:
//   Round-robin arbiter between two ALU issue requesters feeding a single
//   registered output slot toward the ALU redecode/execute stage. The slot
//   can drain and refill in the same cycle, so one op per cycle is issued
//   while downstream keeps i_alu_ready high.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   i_flush              synchronous flush: empties the slot, blocks grants
//   i_reqN_valid/_alu_cmd/_tag   requester N op (N = 0, 1)
//   o_reqN_ready         requester N op accepted this cycle
//   i_alu_ready          downstream takes the registered op this cycle
//   o_alu_valid/_cmd/_tag/_src   registered op and winning requester index
//   o_stat_grant0/1      per-requester grant counters (optional)
//
// Optional feature:
//   Define EXECUTE_ALU_ARB_STAT_EN to add the 16-bit wrapping grant
//   counters o_stat_grant0/o_stat_grant1. They are not cleared by flush.

module execute_alu_issue_arbiter #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_req0_valid,
  input  logic [4:0]       i_req0_alu_cmd,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic             i_req1_valid,
  input  logic [4:0]       i_req1_alu_cmd,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  input  logic             i_alu_ready,
  output logic             o_alu_valid,
  output logic [4:0]       o_alu_cmd,
  output logic [TAG_W-1:0] o_alu_tag,
  output logic             o_alu_src
`ifdef EXECUTE_ALU_ARB_STAT_EN
  ,
  output logic [15:0]      o_stat_grant0,
  output logic [15:0]      o_stat_grant1
`endif
);

  logic             alu_valid_q, alu_valid_d;
  logic [4:0]       alu_cmd_q, alu_cmd_d;
  logic [TAG_W-1:0] alu_tag_q, alu_tag_d;
  logic             alu_src_q, alu_src_d;
  logic             last_grant_q, last_grant_d;

  logic load;
  logic any_req;
  logic gnt_sel;
  logic grant;

  // Slot may accept a new op when it is empty or being drained this cycle.
  // Flush overrides everything. Reset is folded into grant so no requester
  // sees ready while reset is asserted.
  always_comb begin
    load    = !i_flush && (!alu_valid_q || i_alu_ready);
    any_req = i_req0_valid || i_req1_valid;
    // Contended: pick the requester that did not win last. Otherwise the
    // lone valid requester (value is irrelevant when neither is valid).
    gnt_sel = (i_req0_valid && i_req1_valid) ? ~last_grant_q : i_req1_valid;
    grant   = load && any_req && !reset;
    o_req0_ready = grant && !gnt_sel;
    o_req1_ready = grant &&  gnt_sel;
  end

  always_comb begin
    alu_valid_d  = alu_valid_q;
    alu_cmd_d    = alu_cmd_q;
    alu_tag_d    = alu_tag_q;
    alu_src_d    = alu_src_q;
    last_grant_d = last_grant_q;
    if (i_flush) begin
      alu_valid_d = 1'b0;
    end else if (load) begin
      alu_valid_d = any_req;
    end
    if (grant) begin
      alu_cmd_d    = gnt_sel ? i_req1_alu_cmd : i_req0_alu_cmd;
      alu_tag_d    = gnt_sel ? i_req1_tag     : i_req0_tag;
      alu_src_d    = gnt_sel;
      last_grant_d = gnt_sel;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contended cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_valid_q  <= 1'b0;
      alu_cmd_q    <= '0;
      alu_tag_q    <= '0;
      alu_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      alu_valid_q  <= alu_valid_d;
      alu_cmd_q    <= alu_cmd_d;
      alu_tag_q    <= alu_tag_d;
      alu_src_q    <= alu_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_alu_valid = alu_valid_q;
  assign o_alu_cmd   = alu_cmd_q;
  assign o_alu_tag   = alu_tag_q;
  assign o_alu_src   = alu_src_q;

`ifdef EXECUTE_ALU_ARB_STAT_EN
  logic [15:0] stat0_q, stat1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (o_req0_ready) stat0_q <= stat0_q + 16'd1;
      if (o_req1_ready) stat1_q <= stat1_q + 16'd1;
    end
  end

  assign o_stat_grant0 = stat0_q;
  assign o_stat_grant1 = stat1_q;
`endif

endmodule
